// File: rtl/div_hilo_ctrl.sv
// HI/LO divide controller: sign-strips operands for an external combinational divider,
// waits LATENCY cycles, then writes the sign-corrected quotient/remainder to LO/HI.
// Optional feature macro: DIV_BY_ZERO_TRAP_EN (adds dz flag, suppresses HI/LO write on /0).
module div_hilo_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
`ifdef DIV_BY_ZERO_TRAP_EN
  output logic        dz,
`endif
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic        neg_q, neg_r;
  logic        accept, capture, result_ok;
  logic [31:0] mag_a, mag_b;

  assign accept  = start && (state != RUN);
  assign capture = (state == RUN) && (count == 4'd0);

  // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
  assign mag_a = (is_signed && op_a[31]) ? -op_a : op_a;
  assign mag_b = (is_signed && op_b[31]) ? -op_b : op_b;

`ifdef DIV_BY_ZERO_TRAP_EN
  assign result_ok = |div_b;
`else
  assign result_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (count == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_a <= 32'd0;
      div_b <= 32'd0;
      count <= 4'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      div_a <= mag_a;
      div_b <= mag_b;
      count <= 4'(LATENCY - 1);
      neg_q <= is_signed && (op_a[31] ^ op_b[31]);
      neg_r <= is_signed && op_a[31];
    end else if (state == RUN && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  // Direct writes land only outside RUN; a later capture overwrites them.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (capture) begin
      if (result_ok) begin
        lo <= neg_q ? -div_q : div_q;
        hi <= neg_r ? -div_r : div_r;
      end
    end else if (state != RUN) begin
      if (mthi) hi <= wr_data;
      if (mtlo) lo <= wr_data;
    end
  end

`ifdef DIV_BY_ZERO_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                    dz <= 1'b0;
    else if (accept)              dz <= 1'b0;
    else if (capture && !result_ok) dz <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Scoreboard bench for div_hilo_ctrl: expected HI/LO pushed at start, popped and
// compared when done pulses; behavioural divider model drives div_q/div_r.
module tb_div_hilo_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, mthi, mtlo;
  logic [31:0] op_a, op_b, wr_data;
  logic [31:0] div_a, div_b, div_q, div_r, hi, lo;
  logic        busy, done;
`ifdef DIV_BY_ZERO_TRAP_EN
  logic        dz;
`endif

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  // Reference divider: /0 returns all-ones quotient and the dividend as remainder.
  always_comb begin
    if (div_b == 32'd0) begin
      div_q = 32'hFFFF_FFFF;
      div_r = div_a;
    end else begin
      div_q = div_a / div_b;
      div_r = div_a % div_b;
    end
  end

  div_hilo_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .mthi(mthi), .mtlo(mtlo),
    .wr_data(wr_data), .hi(hi), .lo(lo), .busy(busy),
`ifdef DIV_BY_ZERO_TRAP_EN
    .dz(dz),
`endif
    .done(done)
  );

  // Called at a negedge; leaves start asserted across exactly one rising edge.
  task automatic start_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi);
    exp_t e;
    e.name = name; e.lo = elo; e.hi = ehi;
    sb.push_back(e);
    is_signed = sgn; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_op(input logic chk_timing);
    int   cyc = 1;
    int   busy_cnt = 0;
    logic got = 1'b0;
    exp_t e;
    while (cyc < 40) begin
      if (done) begin got = 1'b1; break; end
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (!got) begin
      $display("[TB] FAIL done_timeout: no done within %0d cycles, required done=1", cyc);
      return;
    end else n_pass++;
    n_total++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: done seen with 0 pending, required >=1");
      return;
    end else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (lo !== e.lo) $display("[TB] FAIL %s_lo: got %h, required %h", e.name, lo, e.lo);
    else n_pass++;
    n_total++;
    if (hi !== e.hi) $display("[TB] FAIL %s_hi: got %h, required %h", e.name, hi, e.hi);
    else n_pass++;
    if (chk_timing) begin
      n_total++;
      if (cyc !== LAT + 1) $display("[TB] FAIL %s_latency: got %0d, required %0d", e.name, cyc, LAT + 1);
      else n_pass++;
      n_total++;
      if (busy_cnt !== LAT) $display("[TB] FAIL %s_busy_cycles: got %0d, required %0d", e.name, busy_cnt, LAT);
      else n_pass++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op_a = 32'd0; op_b = 32'd0; wr_data = 32'd0;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if ({hi, lo, div_a, div_b} !== 128'd0)
      $display("[TB] FAIL reset_regs: hi=%h lo=%h div_a=%h div_b=%h, required all 0", hi, lo, div_a, div_b);
    else n_pass++;
    n_total++;
    if ({busy, done} !== 2'b00) $display("[TB] FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
    else n_pass++;
`ifdef DIV_BY_ZERO_TRAP_EN
    n_total++;
    if (dz !== 1'b0) $display("[TB] FAIL reset_dz: got %b, required 0", dz);
    else n_pass++;
`endif
  endtask

  task automatic test_unsigned();
    start_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    finish_op(1'b1);
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("[TB] FAIL u100_7_done_width: done=%b one cycle later, required 0", done);
    else n_pass++;
    start_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);
    finish_op(1'b0);
    idle_cycles(1);
  endtask

  task automatic test_signed();
    start_op("s_m7_2", 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    finish_op(1'b1);
    idle_cycles(1);
    start_op("s_7_m2", 1'b1, 32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1);
    finish_op(1'b0);
    idle_cycles(1);
    start_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    finish_op(1'b0);
    idle_cycles(1);
    start_op("s_m100_m7", 1'b1, -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE);
    finish_op(1'b0);
    idle_cycles(1);
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    start_op("ign50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);
    op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_total++;
    if (dones !== 0) $display("[TB] FAIL ignore_extra_done: got %0d extra pulses, required 0", dones);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int dones = 0;
    mtlo = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    mtlo = 1'b0;
    n_total++;
    if (lo !== 32'h1234) $display("[TB] FAIL mtlo_idle: lo=%h, required 00001234", lo);
    else n_pass++;
    is_signed = 1'b0; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({hi, lo, busy, done} !== 66'd0)
      $display("[TB] FAIL midrun_reset: hi=%h lo=%h busy=%b done=%b, required all 0", hi, lo, busy, done);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_total++;
    if (dones !== 0 || lo !== 32'd0) $display("[TB] FAIL midrun_no_write: dones=%0d lo=%h, required 0 and 0", dones, lo);
    else n_pass++;
    start_op("after_rst9_2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1);
    finish_op(1'b1);
    idle_cycles(1);
  endtask

  task automatic test_div_zero();
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hAA;
    @(negedge clk);
    mtlo = 1'b1; mthi = 1'b0; wr_data = 32'hBB;
    @(negedge clk);
    mtlo = 1'b0;
`ifdef DIV_BY_ZERO_TRAP_EN
    start_op("dz5_0", 1'b0, 32'd5, 32'd0, 32'hBB, 32'hAA);
    finish_op(1'b1);
    n_total++;
    if (dz !== 1'b1) $display("[TB] FAIL dz_set: got %b, required 1", dz);
    else n_pass++;
    idle_cycles(4);
    n_total++;
    if (dz !== 1'b1) $display("[TB] FAIL dz_hold: got %b, required 1", dz);
    else n_pass++;
    start_op("dz_clear8_2", 1'b0, 32'd8, 32'd2, 32'd4, 32'd0);
    n_total++;
    if (dz !== 1'b0) $display("[TB] FAIL dz_clear: got %b, required 0", dz);
    else n_pass++;
    finish_op(1'b0);
`else
    start_op("div0_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    finish_op(1'b1);
    idle_cycles(1);
    start_op("div0_sm5_0", 1'b1, -32'sd5, 32'd0, 32'd1, 32'hFFFF_FFFB);
    finish_op(1'b0);
`endif
    idle_cycles(1);
  endtask

  task automatic test_mthi();
    start_op("mthi20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2);
    mthi = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    mthi = 1'b0;
    finish_op(1'b0);
    @(negedge clk);
    mthi = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    mthi = 1'b0;
    n_total++;
    if (hi !== 32'h55 || lo !== 32'd6) $display("[TB] FAIL mthi_idle: hi=%h lo=%h, required 00000055 00000006", hi, lo);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    mtlo = 1'b1; wr_data = 32'h77;
    start_op("same_cycle8_4", 1'b0, 32'd8, 32'd4, 32'd2, 32'd0);
    mtlo = 1'b0;
    n_total++;
    if (lo !== 32'h77) $display("[TB] FAIL same_cycle_mtlo: lo=%h, required 00000077", lo);
    else n_pass++;
    finish_op(1'b0);
    start_op("b2b100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    finish_op(1'b1);
    start_op("b2b_s_m9_2", 1'b1, -32'sd9, 32'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    finish_op(1'b1);
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_ignore_start();
    test_reset_midrun();
    test_div_zero();
    test_mthi();
    test_back_to_back();
    n_total++;
    if (sb.size() !== 0) $display("[TB] FAIL scoreboard_leftover: %0d pending, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
